// File: rtl/bcd_time_counter_pkg.sv
// Shared constants, packed-BCD digit-pair type and helper functions for the
// BCD time-of-day counter.
package bdc_pkg;

    localparam int unsigned CLK_HZ      = 49152000;
    localparam logic [7:0]  BCD_MAX_SEC = 8'h59;
    localparam logic [7:0]  BCD_MAX_MIN = 8'h59;
    localparam logic [7:0]  BCD_MAX_HR  = 8'h23;

    // One packed-BCD field: tens digit in the upper nibble, units in the lower.
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_pair_t;

    // Field order inside the counter chain: seconds first, hours last.
    localparam int NUM_FIELDS = 3;
    localparam logic [NUM_FIELDS-1:0][7:0] FIELD_MAX = {BCD_MAX_HR, BCD_MAX_MIN, BCD_MAX_SEC};

    // True when both nibbles are decimal digits and the value does not exceed max.
    // Packed BCD orders the same way as the decimal value, so a plain compare works.
    function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    // Decimal increment of a packed-BCD pair; wrapping at the field limit is the caller's job.
    function automatic bcd_pair_t bcd_inc(input bcd_pair_t v);
        bcd_pair_t r;
        if (v.units == 4'd9) begin
            r.tens  = v.tens + 4'd1;
            r.units = 4'd0;
        end else begin
            r.tens  = v.tens;
            r.units = v.units + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_time_counter_if.sv
// Control and time bus of the BCD time counter. The master side drives the
// tick, enable and preset request; the slave (the counter) returns time and strobes.
interface bcd_time_counter_if
    import bdc_pkg::*;
;
    logic      clk_1hz;
    logic      en;
    logic      load;
    bcd_pair_t load_hh;
    bcd_pair_t load_mm;
    bcd_pair_t load_ss;
    bcd_pair_t hh;
    bcd_pair_t mm;
    bcd_pair_t ss;
    logic      sec_pulse;
    logic      day_wrap;
    logic      load_err;

    modport master (
        output clk_1hz, en, load, load_hh, load_mm, load_ss,
        input  hh, mm, ss, sec_pulse, day_wrap, load_err
    );

    modport slave (
        input  clk_1hz, en, load, load_hh, load_mm, load_ss,
        output hh, mm, ss, sec_pulse, day_wrap, load_err
    );
endinterface

// File: rtl/bcd_time_counter_mod_counter.sv
// Two-digit packed-BCD modulo counter: counts 00..MAX, wraps to 00 and
// raises carry in the cycle it wraps. A load overrides an increment.
module bcd_mod_counter
    import bdc_pkg::*;
#(
    parameter logic [7:0] MAX = BCD_MAX_SEC
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      inc,
    input  logic      load,
    input  bcd_pair_t din,
    output bcd_pair_t q,
    output logic      carry
);

    bcd_pair_t q_q;
    bcd_pair_t q_d;
    logic      at_max;

    assign at_max = (q_q == MAX);

    // Next value: preset wins, otherwise advance with wrap at MAX.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = din;
        end else if (inc) begin
            q_d = at_max ? bcd_pair_t'(8'h00) : bcd_inc(q_q);
        end
    end

    // Digit-pair register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= bcd_pair_t'(8'h00);
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc & ~load & at_max;

endmodule

// File: rtl/bcd_time_counter.sv
// Time-of-day counter in packed BCD (hh:mm:ss). Advances once per rising edge
// of the 1 Hz divider output, supports a validated preset and reports a
// per-second strobe, a midnight-wrap strobe and a rejected-preset strobe.
module bcd_time_counter
    import bdc_pkg::*;
#(
    parameter logic EDGE_RESET_VAL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    bcd_time_counter_if.slave  bus
);

    logic                          edge_q;
    logic                          tick;
    logic                          advance;
    logic                          load_ok;
    logic                          load_bad;
    logic [NUM_FIELDS-1:0]         field_ok;
    logic [NUM_FIELDS-1:0]         inc_chain;
    logic [NUM_FIELDS-1:0]         carry;
    logic [NUM_FIELDS-1:0][7:0]    load_val;
    logic [NUM_FIELDS-1:0][7:0]    cnt;
    logic                          sec_pulse_q, sec_pulse_d;
    logic                          day_wrap_q,  day_wrap_d;
    logic                          load_err_q,  load_err_d;

    assign load_val = {bus.load_hh, bus.load_mm, bus.load_ss};

    // A held-high 1 Hz input yields a single tick; the history reset value
    // keeps an already-high input from ticking right after reset.
    assign tick     = bus.clk_1hz & ~edge_q;
    assign load_ok  = bus.load & (&field_ok);
    assign load_bad = bus.load & ~(&field_ok);
    // A load request (accepted or not) swallows a coincident tick.
    assign advance  = tick & bus.en & ~bus.load;

    generate
        for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
            assign field_ok[gi] = bcd_in_range(load_val[gi], FIELD_MAX[gi]);

            if (gi == 0) begin : g_first
                assign inc_chain[gi] = advance;
            end else begin : g_next
                assign inc_chain[gi] = carry[gi-1];
            end

            bcd_mod_counter #(
                .MAX (FIELD_MAX[gi])
            ) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (inc_chain[gi]),
                .load  (load_ok),
                .din   (load_val[gi]),
                .q     (cnt[gi]),
                .carry (carry[gi])
            );
        end
    endgenerate

    // Strobe next-state: all three are single-cycle events.
    always_comb begin
        sec_pulse_d = advance;
        day_wrap_d  = carry[NUM_FIELDS-1];
        load_err_d  = load_bad;
    end

    // Edge history updates every cycle regardless of en/load; strobes are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_q      <= EDGE_RESET_VAL;
            sec_pulse_q <= 1'b0;
            day_wrap_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            edge_q      <= bus.clk_1hz;
            sec_pulse_q <= sec_pulse_d;
            day_wrap_q  <= day_wrap_d;
            load_err_q  <= load_err_d;
        end
    end

    assign bus.ss        = cnt[0];
    assign bus.mm        = cnt[1];
    assign bus.hh        = cnt[2];
    assign bus.sec_pulse = sec_pulse_q;
    assign bus.day_wrap  = day_wrap_q;
    assign bus.load_err  = load_err_q;

endmodule
